truth_table_sequencer: RTL
==========================

Name: truth_table_sequencer

Overview:
Active driver for a 4-input/10-output combinational function board.
- On a start request it sweeps all 16 input codes, 0 to 15, in order.
- For each code it waits a settle interval, captures the 10 result lines, and serialises the code and result as one frame on a single UART-style line.
- It is the hardware counterpart of the bench row loop: it drives the board and reports each truth-table row to a downstream logger.

Parameters:
SETTLE_CYCLES, 6, clocks that stim is held before result is sampled (must be >= 1)
BAUD_DIV, 4, clocks per serial bit (must be >= 1)

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a 16-row sweep; sampled only in IDLE
result  input  10  function board outputs r0..r9 (bit 0 = r0)
stim  output  4  code driven to board inputs {w,x,y,z} (bit 3 = w)
tx  output  1  serial frame line, idle high
busy  output  1  high from first DRIVE cycle through DONE
done  output  1  one-cycle pulse at sweep end
row_idx  output  4  current row index (equals stim)

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values while rst_n=0, applied immediately and without waiting for clk: stim=0, row_idx=0, tx=1, busy=0, done=0, state=IDLE, all counters and shift register cleared.
- Reset mid-sweep aborts the sweep with no partial stop bit; tx goes straight to 1.

States:
- IDLE: tx=1, busy=0. If start=1 on a clk edge, go to DRIVE with row=0.
- DRIVE: stim=row. Hold for exactly SETTLE_CYCLES clocks, then go to CAPTURE.
- CAPTURE: 1 clock. Latch result into a 10-bit capture register. Load the 16-bit frame, sent LSB first:
  - bit 0: start bit (0)
  - bits 1-4: row, LSB first
  - bits 5-14: captured result, r0 first
  - bit 15: stop bit (1)
  - Then go to SEND.
- SEND: each frame bit is held on tx for exactly BAUD_DIV clocks, so the state lasts 16*BAUD_DIV clocks. Then go to NEXT.
- NEXT: 1 clock, tx=1.
  - If row=15, go to DONE.
  - Otherwise row increments by 1 and the next state is DRIVE.
- DONE: 1 clock. done=1 and busy=1, then return to IDLE with row reset to 0.

Rules:
- tx=1 in every state except SEND.
- result is sampled only in CAPTURE. Changes on result at any other time have no effect on the frame.
- start is ignored while busy=1. start held high continuously re-arms a new sweep on the first IDLE cycle after DONE, with no gap beyond that one IDLE cycle.
- Row counter is 4 bits. The 15 to 0 reset happens only via DONE, never by wrap in NEXT.
- Timing:
  - per row: SETTLE_CYCLES + 2 + 16*BAUD_DIV clocks
  - full sweep, first DRIVE clock to the DONE clock: 16*(SETTLE_CYCLES + 2 + 16*BAUD_DIV) clocks
  - with defaults: 72 clocks per row; DONE occurs 1152 clocks after the first DRIVE clock
- Baud counter and settle counter restart at 0 on every state entry.

Test Plan:
- Reset: assert rst_n=0 mid-SEND on row 5 → tx=1, busy=0, stim=0 within the same cycle without a clk edge. After release, the block idles until start.
- Single frame decode: result tied to 10'h2A5, defaults. Row 3 frame on tx, each bit 4 clocks: 0 | 1,1,0,0 | 1,0,1,0,0,1,0,1,0,1 | 1.
- Full sweep: result = {6'b0, stim} (mirror). Decode 16 frames → row fields 0..15 in order, each result field equals its row. done is a single pulse at clock 1152 after the first DRIVE; busy then drops.
- Sampling window: change result during SEND of row 7 → frame carries the value present in row 7's CAPTURE cycle. The row 8 frame carries the new value.
- Start while busy: pulse start during row 2 → no restart, row sequence unaffected. start held high → second sweep's first DRIVE one IDLE clock after done.
- Parameter corner: SETTLE_CYCLES=1, BAUD_DIV=1 → 19 clocks per row, DONE at clock 304, frames decode correctly.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Board-side signal bundle for the truth-table sequencer.
// The master modport is the sequencer; slave is the board/logger side.
interface truth_table_sequencer_if;
  logic       start;
  logic [9:0] result;
  logic [3:0] stim;
  logic       tx;
  logic       busy;
  logic       done;
  logic [3:0] row_idx;

  modport master (
    input  start, result,
    output stim, tx, busy, done, row_idx
  );

  modport slave (
    output start, result,
    input  stim, tx, busy, done, row_idx
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps the 16 input codes of a 4-in/10-out function board and reports
// each row as a 16-bit LSB-first UART-style frame on tx.
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 6,
  parameter int BAUD_DIV      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  bit_r, bit_s;
  logic [3:0]  row_r, row_s;
  logic [15:0] shift_r, shift_s;
  logic [9:0]  cap_r, cap_s;
  logic        tx_r, tx_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

  // Frame layout on the wire: start(0), row LSB first, r0..r9, stop(1).
  function automatic logic [15:0] build_frame(input logic [3:0] row, input logic [9:0] res);
    return {1'b1, res, row, 1'b0};
  endfunction

  // Next-state logic; outputs are derived from the next state so they register aligned with it.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + 16'd1;
    bit_s   = bit_r;
    row_s   = row_r;
    shift_s = shift_r;
    cap_s   = cap_r;
    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        if (bus.start) begin
          state_s = DRIVE;
          row_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = CAPTURE;
          cnt_s   = 16'd0;
        end else begin
          state_s = DRIVE;
        end
      end
      CAPTURE: begin
        cap_s   = bus.result;
        shift_s = build_frame(row_r, bus.result);
        bit_s   = 4'd0;
        cnt_s   = 16'd0;
        state_s = SEND;
      end
      SEND: begin
        if (cnt_r == BAUD_LAST) begin
          cnt_s   = 16'd0;
          shift_s = {1'b1, shift_r[15:1]};
          if (bit_r == 4'd15) begin
            state_s = NEXT;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          state_s = SEND;
        end
      end
      NEXT: begin
        cnt_s = 16'd0;
        // Row 15 exits through DONE; the counter never wraps here.
        if (row_r == 4'd15) begin
          state_s = DONE;
        end else begin
          row_s   = row_r + 4'd1;
          state_s = DRIVE;
        end
      end
      DONE: begin
        cnt_s   = 16'd0;
        row_s   = 4'd0;
        state_s = IDLE;
      end
      default: begin
        cnt_s   = 16'd0;
        row_s   = 4'd0;
        state_s = IDLE;
      end
    endcase

    tx_s   = (state_s == SEND) ? shift_s[0] : 1'b1;
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      bit_r   <= 4'd0;
      row_r   <= 4'd0;
      shift_r <= 16'd0;
      cap_r   <= 10'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      row_r   <= row_s;
      shift_r <= shift_s;
      cap_r   <= cap_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.stim    = row_r;
  assign bus.row_idx = row_r;
  assign bus.tx      = tx_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule
